// File: rtl/fifo_sched_pkg.sv
// Shared types and constants for the FIFO round-robin drain scheduler.
package fifo_sched_pkg;

  // Width of each statistics counter.
  localparam int STATS_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sched_state_e;

  // Width of a queue index. It is never narrower than one bit.
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rr_scheduler_rr_pick.sv
// Rotating priority picker. It finds the first set request strictly after
// base and wraps around, so base itself has the lowest priority.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan offsets 1..N from base. The first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(base) + k) % N]) begin
        found = 1'b1;
        idx   = IW'((int'(base) + k) % N);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Weighted round-robin drain scheduler for a bank of FWFT FIFOs.
// Optional statistics: define FIFO_RR_SCHEDULER_STATS_EN to add the
// stall_cycles and per-queue pops counters.
module fifo_rr_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int NUM_QUEUES = 4,
  parameter int DATA_WIDTH = 32,
  parameter int QUANTUM    = 4,
  localparam int SRC_W     = src_w(NUM_QUEUES)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_QUEUES-1:0]            q_empty,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] q_dout,
  output logic [NUM_QUEUES-1:0]            q_shift_out,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [SRC_W-1:0]                 m_src
`ifdef FIFO_RR_SCHEDULER_STATS_EN
  ,
  output logic [STATS_W-1:0]               stall_cycles,
  output logic [NUM_QUEUES*STATS_W-1:0]    pops
`endif
);

  localparam int CNT_W = $clog2(QUANTUM + 1);

  sched_state_e     state, state_nxt;
  logic [SRC_W-1:0] cur, cur_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SRC_W-1:0] sel, pick_idx;
  logic             have_sel, pick_found;
  logic             load_en;

  assign load_en = !m_valid || m_ready;

  rr_pick #(.N(NUM_QUEUES), .IW(SRC_W)) u_pick (
    .req   (~q_empty),
    .base  (cur),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Select a queue, drive the pop strobe and compute the next grant state.
  always_comb begin
    state_nxt   = state;
    cur_nxt     = cur;
    cnt_nxt     = cnt;
    sel         = pick_idx;
    have_sel    = pick_found;
    q_shift_out = '0;
    if (state == HOLD && !q_empty[cur] && cnt < CNT_W'(QUANTUM)) begin
      sel      = cur;
      have_sel = 1'b1;
    end
    if (rst_n && load_en) begin
      if (have_sel) begin
        q_shift_out[sel] = 1'b1;
        if (state == HOLD && sel == cur) begin
          cnt_nxt = cnt + CNT_W'(1);
        end else begin
          cur_nxt   = sel;
          cnt_nxt   = CNT_W'(1);
          state_nxt = HOLD;
        end
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  // Grant state register. cur resets to the last queue, so the first search starts at queue 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cur   <= SRC_W'(NUM_QUEUES - 1);
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Output stage. It loads the popped word, or it empties when nothing is selectable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_src   <= '0;
    end else if (load_en) begin
      if (have_sel) begin
        m_data  <= q_dout[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
        m_src   <= sel;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

`ifdef FIFO_RR_SCHEDULER_STATS_EN
  // Stall counter saturates at all-ones. The pop counters wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      pops         <= '0;
    end else begin
      if (m_valid && !m_ready && stall_cycles != '1) begin
        stall_cycles <= stall_cycles + STATS_W'(1);
      end
      for (int i = 0; i < NUM_QUEUES; i++) begin
        if (q_shift_out[i]) begin
          pops[i*STATS_W +: STATS_W] <= pops[i*STATS_W +: STATS_W] + STATS_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Scoreboard bench for fifo_rr_scheduler. DUT 0 uses QUANTUM=4 and DUT 1 uses QUANTUM=1.
// Each DUT is fed from a behavioural FWFT FIFO bank.
module tb_fifo_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  q_empty [2];
  logic [127:0] q_dout [2];
  logic [3:0]  q_shift_out [2];
  logic [31:0] m_data [2];
  logic        m_valid [2];
  logic        m_ready [2];
  logic [1:0]  m_src [2];
`ifdef FIFO_RR_SCHEDULER_STATS_EN
  logic [31:0]  stall_cycles [2];
  logic [127:0] pops [2];
`endif

  logic [31:0] fq [8][$];   // FIFO model; index is dut*4 + queue
  logic [33:0] sb [2][$];   // expected {src, data} per DUT
  logic [3:0]  sh [2];
  logic [33:0] mon_e;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_rr_scheduler #(.NUM_QUEUES(4), .DATA_WIDTH(32), .QUANTUM(4)) u_q4 (
    .clk(clk), .rst_n(rst_n), .q_empty(q_empty[0]), .q_dout(q_dout[0]),
    .q_shift_out(q_shift_out[0]), .m_data(m_data[0]), .m_valid(m_valid[0]),
    .m_ready(m_ready[0]), .m_src(m_src[0])
`ifdef FIFO_RR_SCHEDULER_STATS_EN
    , .stall_cycles(stall_cycles[0]), .pops(pops[0])
`endif
  );

  fifo_rr_scheduler #(.NUM_QUEUES(4), .DATA_WIDTH(32), .QUANTUM(1)) u_q1 (
    .clk(clk), .rst_n(rst_n), .q_empty(q_empty[1]), .q_dout(q_dout[1]),
    .q_shift_out(q_shift_out[1]), .m_data(m_data[1]), .m_valid(m_valid[1]),
    .m_ready(m_ready[1]), .m_src(m_src[1])
`ifdef FIFO_RR_SCHEDULER_STATS_EN
    , .stall_cycles(stall_cycles[1]), .pops(pops[1])
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) begin
        q_empty[d][i] = (fq[d*4+i].size() == 0);
        q_dout[d][i*32 +: 32] = (fq[d*4+i].size() != 0) ? fq[d*4+i][0] : 32'h0;
      end
  endtask

  task automatic load(input int d, input int q, input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) fq[d*4+q].push_back(base + 32'(k));
    refresh();
  endtask

  task automatic expect_beat(input int d, input int src, input logic [31:0] data);
    sb[d].push_back({2'(src), data});
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  // Capture the pop strobes mid-cycle and check them against the empty flags.
  // Then pop the model FIFOs at the edge.
  task automatic finish_cycle();
    for (int d = 0; d < 2; d++) begin
      sh[d] = q_shift_out[d];
      chk($sformatf("pop_of_empty_dut%0d", d), 64'(sh[d] & q_empty[d]), 64'h0);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++)
        if (sh[d][i] && fq[d*4+i].size() != 0) void'(fq[d*4+i].pop_front());
    #1 refresh();
  endtask

  task automatic cycle(input int n);
    for (int k = 0; k < n; k++) begin
      to_neg();
      finish_cycle();
    end
  endtask

  task automatic drained(input int d, input string name);
    to_neg();
    chk({name, "_sb_empty"}, 64'(sb[d].size()), 64'h0);
    chk({name, "_valid_low"}, 64'(m_valid[d]), 64'h0);
    finish_cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) fq[i].delete();
    for (int d = 0; d < 2; d++) begin
      sb[d].delete();
      m_ready[d] = 1'b1;
    end
    refresh();
    cycle(2);
    rst_n = 1'b1;
  endtask

  // Monitor: every accepted beat is popped from the scoreboard and compared.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int d = 0; d < 2; d++) begin
          if (m_valid[d] && m_ready[d]) begin
            checks++;
            if (sb[d].size() == 0) begin
              errors++;
              $display("FAIL beat_unexpected dut%0d: got src %0d data %0h expected no beat",
                       d, m_src[d], m_data[d]);
            end else begin
              mon_e = sb[d].pop_front();
              if ({m_src[d], m_data[d]} !== mon_e) begin
                errors++;
                $display("FAIL beat dut%0d: got src %0d data %0h expected src %0d data %0h",
                         d, m_src[d], m_data[d], mon_e[33:32], mon_e[31:0]);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    m_ready[0] = 1'b1;
    m_ready[1] = 1'b1;
    refresh();

    // Reset values
    cycle(1);
    to_neg();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_valid_dut%0d", d), 64'(m_valid[d]), 64'h0);
      chk($sformatf("rst_data_dut%0d", d), 64'(m_data[d]), 64'h0);
      chk($sformatf("rst_src_dut%0d", d), 64'(m_src[d]), 64'h0);
      chk($sformatf("rst_shift_dut%0d", d), 64'(q_shift_out[d]), 64'h0);
    end
    finish_cycle();
    rst_n = 1'b1;

    // Only q0 has words: 10 back-to-back beats across the quantum boundaries
    do_reset();
    load(0, 0, 32'h0, 10);
    for (int k = 0; k < 10; k++) expect_beat(0, 0, 32'(k));
    cycle(11);
    drained(0, "single_q");

    // All four queues have 8 words: src runs in blocks of four
    do_reset();
    for (int q = 0; q < 4; q++) load(0, q, 32'h100 * 32'(q), 8);
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < 4; q++)
        for (int k = 0; k < 4; k++) expect_beat(0, q, 32'h100 * 32'(q) + 32'(r*4 + k));
    cycle(33);
    drained(0, "all_q");

    // m_ready low for 5 cycles: the output stage holds and nothing is popped
    do_reset();
    m_ready[0] = 1'b0;
    load(0, 1, 32'h300, 3);
    for (int k = 0; k < 3; k++) expect_beat(0, 1, 32'h300 + 32'(k));
    cycle(1);
    for (int k = 0; k < 5; k++) begin
      to_neg();
      chk("stall_valid", 64'(m_valid[0]), 64'h1);
      chk("stall_data", 64'(m_data[0]), 64'h300);
      chk("stall_src", 64'(m_src[0]), 64'h1);
      chk("stall_shift", 64'(q_shift_out[0]), 64'h0);
      finish_cycle();
    end
    m_ready[0] = 1'b1;
`ifdef FIFO_RR_SCHEDULER_STATS_EN
    to_neg();
    chk("stall_count", 64'(stall_cycles[0]), 64'h5);
    finish_cycle();
    cycle(2);
`else
    cycle(3);
`endif
    drained(0, "stall");

    // q0 has 1 word, q1 has 2 and q2 has 3: each empties mid-quantum with no bubble
    do_reset();
    load(0, 0, 32'h400, 1);
    load(0, 1, 32'h410, 2);
    load(0, 2, 32'h420, 3);
    expect_beat(0, 0, 32'h400);
    expect_beat(0, 1, 32'h410);
    expect_beat(0, 1, 32'h411);
    for (int k = 0; k < 3; k++) expect_beat(0, 2, 32'h420 + 32'(k));
    cycle(7);
    drained(0, "switch");

    // QUANTUM=1 with q0 and q3 loaded: the grant alternates every beat
    do_reset();
    load(1, 0, 32'h500, 3);
    load(1, 3, 32'h530, 3);
    for (int k = 0; k < 3; k++) begin
      expect_beat(1, 0, 32'h500 + 32'(k));
      expect_beat(1, 3, 32'h530 + 32'(k));
    end
    cycle(7);
    drained(1, "pure_rr");

    // Reset mid-burst on q2: the held word is dropped, no pop occurs, and q0 is granted first
    do_reset();
    load(0, 2, 32'h600, 6);
    expect_beat(0, 2, 32'h600);
    cycle(2);
    rst_n = 1'b0;
    to_neg();
    chk("mid_rst_shift", 64'(q_shift_out[0]), 64'h0);
    finish_cycle();
    chk("mid_rst_q2_level", 64'(fq[2].size()), 64'h4);
    load(0, 0, 32'h610, 2);
    rst_n = 1'b1;
    to_neg();
    chk("post_rst_valid", 64'(m_valid[0]), 64'h0);
    chk("post_rst_data", 64'(m_data[0]), 64'h0);
    chk("post_rst_shift", 64'(q_shift_out[0]), 64'h1);
    expect_beat(0, 0, 32'h610);
    expect_beat(0, 0, 32'h611);
    for (int k = 2; k < 6; k++) expect_beat(0, 2, 32'h600 + 32'(k));
    finish_cycle();
    cycle(6);
    drained(0, "mid_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
